// File: rtl/i2s_tx_sched_if.sv
// Bundle of source-side and transmitter-side signals for i2s_tx_sched.
// The master modport is the scheduler; slave is the surrounding system.
interface i2s_tx_sched_if #(
  parameter int DW   = 24,
  parameter int NSRC = 4,
  parameter int SW   = $clog2(NSRC)
);
  logic                 en;
  logic [7:0]           quantum;
  logic [NSRC-1:0]      src_valid;
  logic [NSRC-1:0]      src_ready;
  logic [NSRC*DW-1:0]   src_ldata;
  logic [NSRC*DW-1:0]   src_rdata;
  logic                 tx_rd_en;
  logic                 tx_rd_valid;
  logic [DW-1:0]        tx_ldata;
  logic [DW-1:0]        tx_rdata;
  logic [SW-1:0]        owner;
  logic                 owner_valid;
  logic [15:0]          underrun_cnt;

  modport master (
    input  en, quantum, src_valid, src_ldata, src_rdata, tx_rd_en,
    output src_ready, tx_rd_valid, tx_ldata, tx_rdata, owner, owner_valid,
           underrun_cnt
  );

  modport slave (
    output en, quantum, src_valid, src_ldata, src_rdata, tx_rd_en,
    input  src_ready, tx_rd_valid, tx_ldata, tx_rdata, owner, owner_valid,
           underrun_cnt
  );
endinterface

// File: rtl/i2s_tx_sched.sv
// Round-robin frame scheduler sharing one I2S transmitter among NSRC stereo
// sources, with per-grant frame quantum, silence substitution and underrun count.
module i2s_tx_sched #(
  parameter int DW   = 24,
  parameter int NSRC = 4,
  localparam int SW  = $clog2(NSRC)
) (
  input logic             clk,
  input logic             rst,
  i2s_tx_sched_if.master  bus
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [SW-1:0]   r_rrPtr;
  logic [SW-1:0]   r_owner;
  logic [7:0]      r_frameCnt;
  logic [15:0]     r_underrunCnt;
  logic            r_txValid;
  logic [DW-1:0]   r_txL;
  logic [DW-1:0]   r_txR;

  logic [SW-1:0]   w_grantIdx;
  logic            w_anyValid;
  logic [NSRC-1:0] w_srcReady;
  logic            w_serve;
  logic            w_underrun;
  logic            w_lastFrame;
  logic [7:0]      w_qEff;
  logic [SW-1:0]   w_nextPtr;
  logic [DW-1:0]   w_selL;
  logic [DW-1:0]   w_selR;

  assign w_anyValid  = |bus.src_valid;
  assign w_qEff      = (bus.quantum == 8'd0) ? 8'd1 : bus.quantum;
  assign w_lastFrame = ({1'b0, r_frameCnt} + 9'd1) >= {1'b0, w_qEff};
  assign w_nextPtr   = (r_owner == SW'(NSRC - 1)) ? '0 : r_owner + SW'(1);
  assign w_selL      = bus.src_ldata[int'(r_owner) * DW +: DW];
  assign w_selR      = bus.src_rdata[int'(r_owner) * DW +: DW];

  // Scan downward so the smallest wrapped offset from rr_ptr wins.
  always_comb begin
    int idx;
    w_grantIdx = r_rrPtr;
    for (int k = NSRC - 1; k >= 0; k--) begin
      idx = int'(r_rrPtr) + k;
      if (idx >= NSRC) idx = idx - NSRC;
      if (bus.src_valid[idx]) w_grantIdx = SW'(idx);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (bus.en && w_anyValid) w_nextState = OWN;
      OWN:  if (!bus.en || w_underrun || (w_serve && w_lastFrame)) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // The pop strobe is combinational so the source advances in the request cycle.
  always_comb begin
    w_serve    = 1'b0;
    w_underrun = 1'b0;
    w_srcReady = '0;
    if (rst && bus.en && (r_state == OWN) && bus.tx_rd_en) begin
      if (bus.src_valid[r_owner]) begin
        w_serve             = 1'b1;
        w_srcReady[r_owner] = 1'b1;
      end else begin
        w_underrun = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rrPtr       <= '0;
      r_owner       <= '0;
      r_frameCnt    <= '0;
      r_underrunCnt <= '0;
      r_txValid     <= 1'b0;
      r_txL         <= '0;
      r_txR         <= '0;
    end else begin
      r_txValid <= bus.tx_rd_en;
      if (bus.tx_rd_en) begin
        r_txL <= w_serve ? w_selL : '0;
        r_txR <= w_serve ? w_selR : '0;
      end
      if ((r_state == IDLE) && (w_nextState == OWN)) begin
        r_owner    <= w_grantIdx;
        r_frameCnt <= '0;
      end
      if (w_serve) r_frameCnt <= r_frameCnt + 8'd1;
      if (w_underrun && (r_underrunCnt != 16'hFFFF))
        r_underrunCnt <= r_underrunCnt + 16'd1;
      if (w_underrun || (w_serve && w_lastFrame)) r_rrPtr <= w_nextPtr;
    end
  end

  assign bus.src_ready    = w_srcReady;
  assign bus.tx_rd_valid  = r_txValid;
  assign bus.tx_ldata     = r_txL;
  assign bus.tx_rdata     = r_txR;
  assign bus.owner        = r_owner;
  assign bus.owner_valid  = (r_state == OWN);
  assign bus.underrun_cnt = r_underrunCnt;

endmodule

// File: tb/tb_i2s_tx_sched.sv
// Self-checking bench for i2s_tx_sched: directed scenarios plus random traffic,
// all compared cycle by cycle against a frame-level ownership model.
module tb_i2s_tx_sched;

  localparam int DW   = 24;
  localparam int NSRC = 4;

  logic clk;
  logic rst;

  i2s_tx_sched_if #(.DW(DW), .NSRC(NSRC)) bus ();

  i2s_tx_sched #(.DW(DW), .NSRC(NSRC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errCount   = 0;
  int checkCount = 0;

  // Model state: who owns the transmitter, how many frames served, what was answered.
  bit          mOwned;
  bit          mOwnerKnown;
  int          mOwner;
  int          mRr;
  int          mCnt;
  logic [15:0] mUnder;
  bit          mRdValid;
  logic [23:0] mL;
  logic [23:0] mR;
  logic [3:0]  mReady;
  bit          useFixed;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelRelease();
    mOwned      = 1'b0;
    mOwnerKnown = 1'b0;
    mRr         = (mOwner + 1) % NSRC;
  endtask

  task automatic applyStimulus(input bit rstN, input bit enI, input bit txI,
                               input logic [3:0] validI, input logic [7:0] qI);
    int qEff;
    @(negedge clk);
    checkOutput("owner_valid", 32'(bus.owner_valid), 32'(mOwned));
    if (mOwned || mOwnerKnown) checkOutput("owner", 32'(bus.owner), 32'(mOwner));
    checkOutput("tx_rd_valid", 32'(bus.tx_rd_valid), 32'(mRdValid));
    checkOutput("tx_ldata", 32'(bus.tx_ldata), 32'(mL));
    checkOutput("tx_rdata", 32'(bus.tx_rdata), 32'(mR));
    checkOutput("underrun_cnt", 32'(bus.underrun_cnt), 32'(mUnder));

    rst           = rstN;
    bus.en        = enI;
    bus.tx_rd_en  = txI;
    bus.src_valid = validI;
    bus.quantum   = qI;
    for (int i = 0; i < NSRC; i++) begin
      bus.src_ldata[i*DW +: DW] = useFixed ? 24'h123456 : 24'($urandom);
      bus.src_rdata[i*DW +: DW] = useFixed ? 24'hABCDEF : 24'($urandom);
    end
    #1;
    mReady = '0;
    if (rstN && mOwned && enI && txI && validI[mOwner]) mReady[mOwner] = 1'b1;
    checkOutput("src_ready", 32'(bus.src_ready), 32'(mReady));

    if (!rstN) begin
      mOwned = 1'b0; mOwnerKnown = 1'b1; mOwner = 0; mRr = 0; mCnt = 0;
      mRdValid = 1'b0; mL = '0; mR = '0; mUnder = '0;
    end else begin
      mRdValid = txI;
      if (txI) begin
        if (mReady != 0) begin
          mL = bus.src_ldata[mOwner*DW +: DW];
          mR = bus.src_rdata[mOwner*DW +: DW];
        end else begin
          mL = '0;
          mR = '0;
        end
      end
      qEff = (qI == 0) ? 1 : int'(qI);
      if (!mOwned) begin
        if (enI && validI != 0) begin
          for (int k = 0; k < NSRC; k++) begin
            if (validI[(mRr + k) % NSRC]) begin
              mOwner = (mRr + k) % NSRC;
              break;
            end
          end
          mOwned = 1'b1; mOwnerKnown = 1'b1; mCnt = 0;
        end
      end else if (!enI) begin
        mOwned      = 1'b0;
        mOwnerKnown = 1'b0;
      end else if (txI) begin
        if (validI[mOwner]) begin
          mCnt++;
          if (mCnt >= qEff) modelRelease();
        end else begin
          if (mUnder != 16'hFFFF) mUnder++;
          modelRelease();
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; bus.en = 1'b0; bus.tx_rd_en = 1'b0; bus.src_valid = '0;
    bus.quantum = 8'd0; bus.src_ldata = '0; bus.src_rdata = '0;
    useFixed = 1'b0;
    mOwned = 1'b0; mOwnerKnown = 1'b1; mOwner = 0; mRr = 0; mCnt = 0;
    mRdValid = 1'b0; mL = '0; mR = '0; mUnder = '0; mReady = '0;

    applyStimulus(0, 0, 1, 4'b1111, 8'd4);
    applyStimulus(0, 1, 0, 4'b0000, 8'd4);

    // Single source 2 with fixed samples, quantum 4.
    useFixed = 1'b1;
    for (int i = 0; i < 24; i++) applyStimulus(1, 1, i[0], 4'b0100, 8'd4);
    useFixed = 1'b0;

    // All sources valid, quantum 2: ownership rotates two frames at a time.
    for (int i = 0; i < 30; i++) applyStimulus(1, 1, i[0], 4'b1111, 8'd2);

    // Steer ownership to source 1, then let it underrun on its second frame.
    applyStimulus(1, 0, 0, 4'b0000, 8'd4);
    applyStimulus(1, 0, 0, 4'b0000, 8'd4);
    applyStimulus(1, 1, 0, 4'b0010, 8'd4);
    applyStimulus(1, 1, 1, 4'b0010, 8'd4);
    applyStimulus(1, 1, 1, 4'b0100, 8'd4);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 1, 4'b0110, 8'd0);

    // Requests with nothing valid, then disable mid-grant.
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1, 4'b0000, 8'd3);
    applyStimulus(1, 1, 0, 4'b1000, 8'd3);
    applyStimulus(1, 1, 1, 4'b1000, 8'd3);
    applyStimulus(1, 0, 1, 4'b1000, 8'd3);
    applyStimulus(1, 1, 0, 4'b1001, 8'd3);
    applyStimulus(1, 1, 0, 4'b1001, 8'd3);

    // Back-to-back requests, then reset while a grant is held.
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1, 4'b1111, 8'd8);
    applyStimulus(1, 1, 1, 4'b1111, 8'd8);
    applyStimulus(0, 1, 1, 4'b1111, 8'd8);
    applyStimulus(1, 1, 0, 4'b1111, 8'd8);
    applyStimulus(1, 1, 1, 4'b1111, 8'd8);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] v;
      v = 4'($urandom);
      if ($urandom_range(0, 3) != 0) v = v | 4'($urandom);
      applyStimulus(($urandom_range(0, 299) != 0), ($urandom_range(0, 15) != 0),
                    1'($urandom), v, 8'($urandom_range(0, 5)));
    end

    // Saturation: preload the counter near the top, then underrun repeatedly.
    applyStimulus(1, 0, 0, 4'b0000, 8'd1);
    applyStimulus(1, 0, 0, 4'b0000, 8'd1);
    force dut.r_underrunCnt = 16'hFFFD;
    #1;
    release dut.r_underrunCnt;
    mUnder = 16'hFFFD;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 0, 4'b1111, 8'd1);
      applyStimulus(1, 1, 1, 4'b0000, 8'd1);
    end
    applyStimulus(1, 1, 0, 4'b0000, 8'd1);
    applyStimulus(1, 1, 0, 4'b0000, 8'd1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/i2s_tx_sched.md
# i2s_tx_sched

Frame-level scheduler that shares the single I2S transmitter among `NSRC` stereo sample sources. It answers the transmitter's `tx_rd_en`/`tx_rd_valid` sample-request handshake. Sources get round-robin ownership for a programmable quantum of frames, with silence substitution and underrun accounting. It sits between the audio source FIFOs and the `i2s` block's transmit port, in the `clk` domain.

## Interface
- `DW`, 24: sample width per channel.
- `NSRC`, 4: number of sources, 2..16; `SW = $clog2(NSRC)`.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-low reset.
- `en`  in  1  scheduler enable; low forces release and silence.
- `quantum`  in  8  frames per ownership grant; 0 treated as 1.
- `src_valid`  in  NSRC  source i has a stereo sample pair available.
- `src_ready`  out  NSRC  pop strobe to source i.
- `src_ldata`  in  NSRC*DW  left samples; source i at bits [i*DW +: DW].
- `src_rdata`  in  NSRC*DW  right samples, same packing.
- `tx_rd_en`  in  1  sample request from transmitter, one-cycle pulse.
- `tx_rd_valid`  out  1  response strobe, one cycle.
- `tx_ldata`, `tx_rdata`  out  DW  response sample pair.
- `owner`  out  SW  current owner index.
- `owner_valid`  out  1  high in OWN state.
- `underrun_cnt`  out  16  saturating underrun count.

## Operation
- States: IDLE (no owner) and OWN (owner holds transmitter). Registers: `rr_ptr` (SW), `frame_cnt` (8), `owner`, `underrun_cnt`.
- IDLE, `en`=1, any `src_valid`: grant the first valid index at or after `rr_ptr`, searching upward with wrap. Next cycle: OWN, `owner`=grantee, `frame_cnt`=0.
- OWN, `tx_rd_en`, `src_valid[owner]`=1: `src_ready[owner]`=1 the same cycle (combinational). Capture that source's pair, then increment `frame_cnt`.
- OWN, `tx_rd_en`, `src_valid[owner]`=0: underrun. Respond with zeros, saturate-increment `underrun_cnt`, release immediately.
- Quantum expiry: when `frame_cnt`+1 reaches max(`quantum`,1) on a serviced frame, release after that frame.
- Release: `rr_ptr` = (`owner`+1) mod `NSRC`; next state IDLE. Re-grant is possible no earlier than the cycle after entering IDLE.
- `tx_rd_en` in IDLE: respond with zeros, no count. If a grant resolves the same cycle, the grant still takes effect; the request stays silence.
- `en`=0: `src_ready` forced 0 and all responses are zeros. An OWN state moves to IDLE at the next edge with `rr_ptr` unchanged. No underrun is counted.
- `src_ready` is high only as defined above: at most one bit set, never without `tx_rd_en`.
- `quantum` is sampled per frame. A mid-grant change takes effect at the next serviced frame's comparison.

## Timing
- Reset (`rst`=0 at edge) gives: IDLE, `rr_ptr`=0, `frame_cnt`=0, `owner`=0, `owner_valid`=0, `tx_rd_valid`=0, `tx_ldata`/`tx_rdata`=0, `underrun_cnt`=0. `src_ready`=0 while in reset.
- Reset mid-grant abandons ownership with no pop and no response.
- Response latency: `tx_rd_en` at cycle T gives `tx_rd_valid`=1 at T+1, with data registered. Data holds until the next response.
- Every `tx_rd_en` gets exactly one `tx_rd_valid`, including back-to-back requests on consecutive cycles.
- Grant latency: `src_valid` rising in IDLE at T gives `owner_valid`=1 at T+1.
- Release-to-regrant: at least one IDLE cycle. A `tx_rd_en` landing in that cycle is served as silence.
- `underrun_cnt` saturates at 16'hFFFF.

## Test plan
- Single source: NSRC=4, `quantum`=4, only src 2 valid with L=0x123456, R=0xABCDEF. Each `tx_rd_en` gives `src_ready[2]` at T, then `tx_rd_valid` with 0x123456/0xABCDEF at T+1. `owner` alternates 2 -> IDLE -> 2 every 4 frames.
- Round robin: all sources always valid, `quantum`=2. Owners go 0,0,1,1,2,2,3,3,0 across frames, with no double-pop and exactly one `src_ready` per request.
- Underrun: src 1 owns and deasserts valid before frame 2. Frame 2 returns 0/0, `underrun_cnt`=1, then grant passes to src 2. `quantum`=0 behaves as 1.
- IDLE/disable: `tx_rd_en` with no valid sources returns zeros and the count stays 0. Dropping `en` mid-grant gives IDLE next edge, zeros, `rr_ptr` unchanged.
- Back-to-back `tx_rd_en` on consecutive cycles: two pops, two responses at T+1 and T+2. Then assert `rst`=0 mid-grant: all outputs return to reset values next edge.
- Saturation: force 65536 underruns; `underrun_cnt` holds 0xFFFF.
